// File: rtl/elevator_pkg.sv
// Shared types, sizing constants and floor-mask helpers for the single-car elevator controller.
package elevator_pkg;

  localparam int FLOOR_W    = 3;
  localparam int MAX_FLOORS = 8;
  localparam int TIMER_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } state_t;

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

  function automatic logic [MAX_FLOORS-1:0] lowMask(input int n);
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_FLOORS; i++) m[i] = (i < n);
    return m;
  endfunction

  function automatic logic [MAX_FLOORS-1:0] aboveMask(input logic [FLOOR_W-1:0] f);
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [MAX_FLOORS-1:0] belowMask(input logic [FLOOR_W-1:0] f);
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// Request inputs and car status outputs between the input processor/display logic and the scheduler.
interface elevator_scheduler_if;
  import elevator_pkg::*;

  logic [MAX_FLOORS-1:0] up;
  logic [MAX_FLOORS-1:0] down;
  logic [MAX_FLOORS-1:0] elevator_btn;
  logic [FLOOR_W-1:0]    floor;
  logic                  moving_up;
  logic                  moving_down;
  logic                  door_open;
  logic [MAX_FLOORS-1:0] pending_up;
  logic [MAX_FLOORS-1:0] pending_down;
  logic [MAX_FLOORS-1:0] pending_car;

  modport master (
    output up, down, elevator_btn,
    input  floor, moving_up, moving_down, door_open,
    input  pending_up, pending_down, pending_car
  );

  modport slave (
    input  up, down, elevator_btn,
    output floor, moving_up, moving_down, door_open,
    output pending_up, pending_down, pending_car
  );

endinterface

// File: rtl/elevator_timer.sv
// Loadable down-counter that holds at zero; used for per-floor travel time and door dwell.
module elevator_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car scheduler: latches calls, runs a direction-preserving sweep, and times travel and door dwell.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS        = 8,
  parameter int TRAVEL_CYCLES = 50000000,
  parameter int DOOR_CYCLES   = 100000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  elevator_scheduler_if.slave  bus
);

  // Top floor has no up call and floor 0 has no down call.
  localparam logic [MAX_FLOORS-1:0] UP_MASK   = lowMask(FLOORS - 1);
  localparam logic [MAX_FLOORS-1:0] DOWN_MASK = lowMask(FLOORS) & ~lowMask(1);
  localparam logic [MAX_FLOORS-1:0] CAR_MASK  = lowMask(FLOORS);
  localparam logic [MAX_FLOORS-1:0] ONE_HOT0  = MAX_FLOORS'(1);
  localparam logic [FLOOR_W-1:0]    FLOOR_TOP = FLOOR_W'(FLOORS - 1);
  localparam logic [TIMER_W-1:0]    TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0]    DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

  state_t                r_state, w_stateNext;
  dir_t                  r_sweepDir, w_dirNext;
  logic [FLOOR_W-1:0]    r_floor, w_floorNext, w_floorUp, w_floorDown;
  logic [MAX_FLOORS-1:0] r_pendingUp, r_pendingDown, r_pendingCar;
  logic [MAX_FLOORS-1:0] w_clearUp, w_clearDown, w_clearCar;
  logic [MAX_FLOORS-1:0] w_anyPending, w_hereMask;
  logic                  w_here, w_above, w_below, w_aboveNext, w_belowNext;
  logic                  w_travelLoad, w_doorLoad, w_travelZero, w_doorZero;

  assign w_anyPending = r_pendingUp | r_pendingDown | r_pendingCar;
  assign w_hereMask   = ONE_HOT0 << r_floor;
  assign w_floorUp    = r_floor + 1'b1;
  assign w_floorDown  = r_floor - 1'b1;
  assign w_here       = |(w_anyPending & w_hereMask);
  assign w_above      = |(w_anyPending & aboveMask(r_floor));
  assign w_below      = |(w_anyPending & belowMask(r_floor));
  assign w_aboveNext  = |(w_anyPending & aboveMask(w_floorUp));
  assign w_belowNext  = |(w_anyPending & belowMask(w_floorDown));

  elevator_timer #(.WIDTH(TIMER_W)) u_travelTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_travelLoad),
    .i_value (TRAVEL_LOAD),
    .o_zero  (w_travelZero)
  );

  elevator_timer #(.WIDTH(TIMER_W)) u_doorTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_doorLoad),
    .i_value (DOOR_LOAD),
    .o_zero  (w_doorZero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_sweepDir    <= UP;
      r_floor       <= '0;
      r_pendingUp   <= '0;
      r_pendingDown <= '0;
      r_pendingCar  <= '0;
    end else begin
      r_state       <= w_stateNext;
      r_sweepDir    <= w_dirNext;
      r_floor       <= w_floorNext;
      r_pendingUp   <= (r_pendingUp   | (bus.up           & UP_MASK))   & ~w_clearUp;
      r_pendingDown <= (r_pendingDown | (bus.down         & DOWN_MASK)) & ~w_clearDown;
      r_pendingCar  <= (r_pendingCar  | (bus.elevator_btn & CAR_MASK))  & ~w_clearCar;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_dirNext    = r_sweepDir;
    w_floorNext  = r_floor;
    w_travelLoad = 1'b0;
    w_doorLoad   = 1'b0;
    w_clearUp    = '0;
    w_clearDown  = '0;
    w_clearCar   = '0;

    case (r_state)
      IDLE: begin
        if (w_here) begin
          w_stateNext = DOOR_OPEN;
          w_doorLoad  = 1'b1;
          if (r_pendingUp[r_floor])        w_dirNext = UP;
          else if (r_pendingDown[r_floor]) w_dirNext = DOWN;
        end else if (w_above) begin
          w_stateNext  = MOVE_UP;
          w_dirNext    = UP;
          w_travelLoad = 1'b1;
        end else if (w_below) begin
          w_stateNext  = MOVE_DOWN;
          w_dirNext    = DOWN;
          w_travelLoad = 1'b1;
        end
      end

      MOVE_UP: begin
        if (w_travelZero) begin
          if (r_floor == FLOOR_TOP) begin
            w_stateNext = IDLE;
          end else begin
            w_floorNext = w_floorUp;
            if (r_pendingCar[w_floorUp] | r_pendingUp[w_floorUp]) begin
              w_stateNext = DOOR_OPEN;
              w_doorLoad  = 1'b1;
              w_dirNext   = UP;
            end else if (r_pendingDown[w_floorUp] & ~w_aboveNext) begin
              w_stateNext = DOOR_OPEN;
              w_doorLoad  = 1'b1;
              w_dirNext   = DOWN;
            end else if (w_aboveNext) begin
              w_travelLoad = 1'b1;
            end else begin
              w_stateNext = IDLE;
            end
          end
        end
      end

      MOVE_DOWN: begin
        if (w_travelZero) begin
          if (r_floor == '0) begin
            w_stateNext = IDLE;
          end else begin
            w_floorNext = w_floorDown;
            if (r_pendingCar[w_floorDown] | r_pendingDown[w_floorDown]) begin
              w_stateNext = DOOR_OPEN;
              w_doorLoad  = 1'b1;
              w_dirNext   = DOWN;
            end else if (r_pendingUp[w_floorDown] & ~w_belowNext) begin
              w_stateNext = DOOR_OPEN;
              w_doorLoad  = 1'b1;
              w_dirNext   = UP;
            end else if (w_belowNext) begin
              w_travelLoad = 1'b1;
            end else begin
              w_stateNext = IDLE;
            end
          end
        end
      end

      DOOR_OPEN: begin
        // Held buttons for this stop are swallowed for the whole dwell.
        w_clearCar = w_hereMask;
        if (r_sweepDir == UP) w_clearUp   = w_hereMask;
        else                  w_clearDown = w_hereMask;
        if (w_doorZero) begin
          if (r_sweepDir == UP) begin
            if (w_above) begin
              w_stateNext  = MOVE_UP;
              w_travelLoad = 1'b1;
            end else if (w_below) begin
              w_stateNext  = MOVE_DOWN;
              w_dirNext    = DOWN;
              w_travelLoad = 1'b1;
            end else begin
              w_stateNext = IDLE;
            end
          end else begin
            if (w_below) begin
              w_stateNext  = MOVE_DOWN;
              w_travelLoad = 1'b1;
            end else if (w_above) begin
              w_stateNext  = MOVE_UP;
              w_dirNext    = UP;
              w_travelLoad = 1'b1;
            end else begin
              w_stateNext = IDLE;
            end
          end
        end
      end

      default: w_stateNext = IDLE;
    endcase
  end

  assign bus.floor        = r_floor;
  assign bus.moving_up    = (r_state == MOVE_UP);
  assign bus.moving_down  = (r_state == MOVE_DOWN);
  assign bus.door_open    = (r_state == DOOR_OPEN);
  assign bus.pending_up   = r_pendingUp;
  assign bus.pending_down = r_pendingDown;
  assign bus.pending_car  = r_pendingCar;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with short travel/dwell times: vector table plus multi-stop sequences.
module tb_elevator_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;

  always #5 clk = ~clk;

  elevator_scheduler_if bus();

  elevator_scheduler #(
    .FLOORS        (8),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] up;
    logic [7:0] down;
    logic [7:0] btn;
    logic [7:0] cycles;
    logic [2:0] floor;
    logic       mvUp;
    logic       mvDown;
    logic       door;
    logic [7:0] pUp;
    logic [7:0] pDown;
    logic [7:0] pCar;
  } vec_t;

  vec_t vecs [15];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] u, input logic [7:0] d, input logic [7:0] b);
    bus.up = u;
    bus.down = d;
    bus.elevator_btn = b;
    step(1);
    bus.up = '0;
    bus.down = '0;
    bus.elevator_btn = '0;
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, ".floor"},  32'(bus.floor),        32'(v.floor));
    checkOutput({tag, ".mvUp"},   32'(bus.moving_up),    32'(v.mvUp));
    checkOutput({tag, ".mvDown"}, 32'(bus.moving_down),  32'(v.mvDown));
    checkOutput({tag, ".door"},   32'(bus.door_open),    32'(v.door));
    checkOutput({tag, ".pUp"},    32'(bus.pending_up),   32'(v.pUp));
    checkOutput({tag, ".pDown"},  32'(bus.pending_down), 32'(v.pDown));
    checkOutput({tag, ".pCar"},   32'(bus.pending_car),  32'(v.pCar));
  endtask

  task automatic waitDoorOpen(input int budget, input logic [2:0] expFloor, input string name);
    int n = 0;
    while (bus.door_open && n < budget) begin step(1); n++; end
    while (!bus.door_open && n < budget) begin step(1); n++; end
    if (!bus.door_open) checkOutput({name, ".timeoutDoor"}, 32'(bus.door_open), 32'd1);
    else                checkOutput({name, ".floor"}, 32'(bus.floor), 32'(expFloor));
  endtask

  task automatic waitIdle(input int budget, input logic [2:0] expFloor, input string name);
    int n = 0;
    while ((bus.door_open || bus.moving_up || bus.moving_down) && n < budget) begin step(1); n++; end
    checkOutput({name, ".busy"}, 32'({bus.door_open, bus.moving_up, bus.moving_down}), 32'd0);
    checkOutput({name, ".floor"}, 32'(bus.floor), 32'(expFloor));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t zero;
    int n;
    zero = '0;
    bus.up = '0;
    bus.down = '0;
    bus.elevator_btn = '0;

    //          up     down   btn    cyc  floor mvU   mvD   door  pUp    pDown  pCar
    vecs[0]  = '{8'h00, 8'h00, 8'h01, 8'd1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01};
    vecs[1]  = '{8'h00, 8'h00, 8'h00, 8'd1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01};
    vecs[2]  = '{8'h00, 8'h00, 8'h00, 8'd1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[3]  = '{8'h00, 8'h00, 8'h00, 8'd1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{8'h00, 8'h00, 8'h00, 8'd1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[5]  = '{8'h00, 8'h00, 8'h08, 8'd1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h08};
    vecs[6]  = '{8'h00, 8'h00, 8'h00, 8'd1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h08};
    vecs[7]  = '{8'h00, 8'h00, 8'h00, 8'd4, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h08};
    vecs[8]  = '{8'h00, 8'h00, 8'h00, 8'd3, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h08};
    vecs[9]  = '{8'h00, 8'h00, 8'h00, 8'd1, 3'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h08};
    vecs[10] = '{8'h00, 8'h00, 8'h00, 8'd4, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h08};
    vecs[11] = '{8'h00, 8'h00, 8'h00, 8'd1, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[12] = '{8'h00, 8'h00, 8'h00, 8'd1, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[13] = '{8'h00, 8'h00, 8'h00, 8'd1, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[14] = '{8'h80, 8'h01, 8'h00, 8'd2, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};

    rst_n = 1'b0;
    step(2);
    checkAll("reset", zero);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].up, vecs[i].down, vecs[i].btn);
      step(int'(vecs[i].cycles) - 1);
      checkAll($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset from an idle car at floor 3, then reset again mid-travel between floors 2 and 3.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checkOutput("rstIdle.floor", 32'(bus.floor), 32'd0);
    applyStimulus(8'h00, 8'h00, 8'h20);
    n = 0;
    while (!(bus.floor == 3'd2 && bus.moving_up) && n < 100) begin step(1); n++; end
    checkOutput("rstMove.reachedFloor2", 32'(bus.floor), 32'd2);
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checkAll("rstMove", zero);
    step(2);
    checkOutput("rstMove.noSurvivor", 32'({bus.moving_up, bus.moving_down, bus.door_open}), 32'd0);

    // Sweep up from 0 to car call 5, picking up the up call at 2 and coming back for the down call.
    applyStimulus(8'h00, 8'h00, 8'h20);
    step(1);
    checkOutput("sweep.startUp", 32'(bus.moving_up), 32'd1);
    applyStimulus(8'h04, 8'h04, 8'h00);
    waitDoorOpen(200, 3'd2, "sweep.stopUpCall2");
    checkOutput("sweep.keepDown2", 32'(bus.pending_down), 32'h04);
    checkOutput("sweep.keepCar5", 32'(bus.pending_car), 32'h20);
    step(1);
    checkOutput("sweep.clearUp2", 32'(bus.pending_up), 32'h00);
    checkOutput("sweep.stillDown2", 32'(bus.pending_down), 32'h04);
    waitDoorOpen(200, 3'd5, "sweep.stopCar5");
    waitDoorOpen(200, 3'd2, "sweep.returnDown2");
    waitIdle(200, 3'd2, "sweep.idle");
    checkOutput("sweep.allClear", 32'({bus.pending_up, bus.pending_down, bus.pending_car}), 32'd0);

    // Park at 4, then calls above and below arrive together: up side served first.
    applyStimulus(8'h00, 8'h00, 8'h10);
    waitDoorOpen(200, 3'd4, "tie.park4");
    waitIdle(200, 3'd4, "tie.idle4");
    applyStimulus(8'h00, 8'h80, 8'h02);
    step(1);
    checkOutput("tie.upWins", 32'(bus.moving_up), 32'd1);
    waitDoorOpen(200, 3'd7, "tie.first7");
    waitDoorOpen(200, 3'd1, "tie.then1");
    waitIdle(200, 3'd1, "tie.idle1");

    // Car button held through the dwell at floor 2 cannot re-arm until the door closes.
    bus.elevator_btn = 8'h04;
    waitDoorOpen(200, 3'd2, "held.stop2");
    step(1);
    checkOutput("held.dwell1.pCar2", 32'(bus.pending_car[2]), 32'd0);
    checkOutput("held.dwell1.door", 32'(bus.door_open), 32'd1);
    step(1);
    checkOutput("held.dwell2.pCar2", 32'(bus.pending_car[2]), 32'd0);
    checkOutput("held.dwell2.door", 32'(bus.door_open), 32'd1);
    step(1);
    checkOutput("held.closed.door", 32'(bus.door_open), 32'd0);
    checkOutput("held.closed.pCar2", 32'(bus.pending_car[2]), 32'd0);
    step(1);
    checkOutput("held.rearm.pCar2", 32'(bus.pending_car[2]), 32'd1);
    bus.elevator_btn = 8'h00;
    step(1);
    waitIdle(200, 3'd2, "held.idle");
    checkOutput("held.finalClear", 32'(bus.pending_car), 32'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
